// File: rtl/conv_sequencer_pkg.sv
// Shared constants and state encoding for the 3x3, 4-filter convolution sequencer.
package conv_sequencer_pkg;

    localparam int KERNEL_TAPS = 9;
    localparam int NUM_FILTERS = 4;
    localparam int TAP_W       = $clog2(KERNEL_TAPS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WLOAD  = 3'd1,
        ST_WLAST  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/conv_sequencer_window_credit_counter.sv
// Tracks windows popped vs. psum groups returned; grants pops while credit remains.
module window_credit_counter #(
    parameter int CNT_W           = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             pop,
    input  logic             psum_en,
    input  logic [CNT_W-1:0] num_windows,
    output logic [CNT_W-1:0] psum_count,
    output logic             can_issue,
    output logic             last_pop,
    output logic             all_returned
);

    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] psum_next;
    logic             psum_inc;

    // Both counters are registered, so a same-cycle pop and return leave outstanding unchanged.
    assign outstanding  = issued - psum_count;
    assign can_issue    = (issued < num_windows) && (outstanding < MAX_OUT);
    assign last_pop     = pop && ((issued + ONE) == num_windows);
    assign psum_inc     = psum_en && (psum_count < num_windows);
    assign psum_next    = psum_inc ? psum_count + ONE : psum_count;
    assign all_returned = (psum_next == num_windows);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            issued     <= '0;
            psum_count <= '0;
        end else begin
            if (pop)
                issued <= issued + ONE;
            psum_count <= psum_next;
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Sequences one convolution pass: weight fetch/load, credit-metered window pops, psum drain.
module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int CNT_W           = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] wbase,
    input  logic [CNT_W-1:0]  num_windows,
    output logic              busy,
    output logic              done,
    output logic              wload_err,
    output logic              wbuf_ren,
    output logic [ADDR_W-1:0] wbuf_addr,
    output logic              core_weight_load,
    input  logic              core_weight_load_done,
    input  logic              ff_empty,
    output logic              ff_ren,
    input  logic              core_psum_vld,
    output logic [CNT_W-1:0]  psum_count
);

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERNEL_TAPS - 1);

    state_t            state, state_nxt;
    logic [TAP_W-1:0]  k;
    logic [ADDR_W-1:0] wbase_q;
    logic [CNT_W-1:0]  num_q;
    logic              clear;
    logic              psum_en;
    logic              can_issue;
    logic              last_pop;
    logic              all_returned;

    window_credit_counter #(
        .CNT_W          (CNT_W),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .pop         (ff_ren),
        .psum_en     (psum_en),
        .num_windows (num_q),
        .psum_count  (psum_count),
        .can_issue   (can_issue),
        .last_pop    (last_pop),
        .all_returned(all_returned)
    );

    // Returns outside the streaming window are stray and must not count.
    assign psum_en   = core_psum_vld && ((state == ST_STREAM) || (state == ST_DRAIN));
    assign wbuf_addr = wbuf_ren ? (wbase_q + ADDR_W'(k)) : '0;

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        wbuf_ren  = 1'b0;
        ff_ren    = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = ST_WLOAD;
                end
            end
            ST_WLOAD: begin
                wbuf_ren = 1'b1;
                if (k == LAST_TAP)
                    state_nxt = ST_WLAST;
            end
            ST_WLAST: begin
                state_nxt = (num_q == '0) ? ST_DONE : ST_STREAM;
            end
            ST_STREAM: begin
                // Never pop while the core is still shifting in weights.
                ff_ren = !ff_empty && can_issue && !core_weight_load;
                if (last_pop)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (all_returned)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            k                <= '0;
            wbase_q          <= '0;
            num_q            <= '0;
            wload_err        <= 1'b0;
            core_weight_load <= 1'b0;
        end else begin
            state            <= state_nxt;
            core_weight_load <= wbuf_ren;
            if (clear) begin
                wbase_q   <= wbase;
                num_q     <= num_windows;
                k         <= '0;
                wload_err <= 1'b0;
            end else if (state == ST_WLOAD) begin
                k <= k + 1'b1;
            end
            if ((state == ST_WLAST) && !core_weight_load_done)
                wload_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench: two sequencers (credit limits 4 and 2) driven in lockstep against behavioural core models.
module tb_conv_sequencer;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;
    localparam int TAPS   = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              ff_empty = 1'b1;
    logic [ADDR_W-1:0] wbase = '0;
    logic [CNT_W-1:0]  num_windows = '0;

    logic [1:0]        busy, done, wload_err, wbuf_ren, cwl, cwl_done, ff_ren, psum_vld;
    logic [ADDR_W-1:0] wbuf_addr [2];
    logic [CNT_W-1:0]  psum_count [2];

    logic hold = 1'b0, inj = 1'b0, kill = 1'b0, pass_on = 1'b0;
    int   n_chk = 0, n_fail = 0, gcyc = 0, t0 = 0;

    logic [ADDR_W-1:0] addr_q0[$], addr_q1[$];
    int   wren_n[2], cwl_n[2], cwl_first[2], cwl_last[2], iss[2], ret[2];
    int   done_n[2], done_cyc[2], ret_cyc[2], drop_cyc[2];
    logic [63:0] popmask[2];

    always #5 clk = ~clk;
    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int MAXO = (g == 0) ? 4 : 2;

        conv_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_OUTSTANDING(MAXO)) u_dut (
            .clk                  (clk),
            .rst                  (rst),
            .start                (start),
            .wbase                (wbase),
            .num_windows          (num_windows),
            .busy                 (busy[g]),
            .done                 (done[g]),
            .wload_err            (wload_err[g]),
            .wbuf_ren             (wbuf_ren[g]),
            .wbuf_addr            (wbuf_addr[g]),
            .core_weight_load     (cwl[g]),
            .core_weight_load_done(cwl_done[g]),
            .ff_empty             (ff_empty),
            .ff_ren               (ff_ren[g]),
            .core_psum_vld        (psum_vld[g]),
            .psum_count           (psum_count[g])
        );

        // Core model: psum returns 3 cycles after a pop (queued while held); load_done on loads 8 and 9.
        logic [2:0] pp = '0;
        int         pend = 0;
        int         ldn = 0;
        logic       dlv;
        assign dlv         = !hold && (pp[2] || (pend > 0));
        assign psum_vld[g] = inj || dlv;
        assign cwl_done[g] = cwl[g] && (ldn >= 7) && !kill;

        always @(posedge clk) begin
            if (rst) begin
                pp <= '0; pend <= 0; ldn <= 0;
            end else begin
                pp   <= {pp[1:0], ff_ren[g]};
                pend <= pend + int'(pp[2]) - int'(dlv);
                ldn  <= cwl[g] ? ldn + 1 : 0;
            end
        end

        initial begin
            int rel;
            logic exp_ren;
            logic [ADDR_W-1:0] ea;
            forever begin
                @(negedge clk);
                if (pass_on) begin
                    rel = gcyc - t0;
                    if (rel == 1) begin
                        wren_n[g] = 0; cwl_n[g] = 0; cwl_first[g] = 0; cwl_last[g] = 0;
                        iss[g] = 0; ret[g] = 0; done_n[g] = 0; done_cyc[g] = 0;
                        ret_cyc[g] = 0; drop_cyc[g] = 0; popmask[g] = '0;
                        chk("err_clear", wload_err[g], 0);
                    end
                    if (wbuf_ren[g]) begin
                        wren_n[g]++;
                        if ((g == 0 ? addr_q0.size() : addr_q1.size()) == 0)
                            chk("wren_extra", wbuf_ren[g], 0);
                        else begin
                            if (g == 0) ea = addr_q0.pop_front();
                            else        ea = addr_q1.pop_front();
                            chk("wbuf_addr", wbuf_addr[g], ea);
                        end
                    end
                    if (cwl[g]) begin
                        if (cwl_n[g] == 0) cwl_first[g] = rel;
                        cwl_last[g] = rel;
                        cwl_n[g]++;
                    end
                    exp_ren = (rel >= 11) && !ff_empty && (iss[g] < int'(num_windows))
                              && ((iss[g] - ret[g]) < MAXO);
                    chk("ff_ren", ff_ren[g], exp_ren);
                    chk("psum_count", psum_count[g], ret[g]);
                    if (ff_ren[g]) begin
                        chk("pop_guard", cwl[g], 0);
                        chk("pop_empty", ff_empty, 0);
                        iss[g]++;
                        if (rel < 64) popmask[g][rel] = 1'b1;
                    end
                    if (psum_vld[g] && (rel >= 11) && (ret[g] < int'(num_windows))) begin
                        ret[g]++;
                        ret_cyc[g] = rel;
                    end
                    if (done[g]) begin
                        done_n[g]++;
                        done_cyc[g] = rel;
                    end
                    if (!busy[g] && drop_cyc[g] == 0) drop_cyc[g] = rel;
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk({tag, "_ctl"}, {busy[g], done[g], wload_err[g], wbuf_ren[g], cwl[g], ff_ren[g]}, 0);
            chk({tag, "_addr"}, wbuf_addr[g], 0);
            chk({tag, "_psum"}, psum_count[g], 0);
        end
    endtask

    task automatic run_pass(input logic [ADDR_W-1:0] wb, input logic [CNT_W-1:0] nw,
                            input int hold_until, input logic emp, input logic kil,
                            input logic hold_start, input logic abort);
        int rel;
        wbase = wb; num_windows = nw; kill = kil; ff_empty = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            addr_q0.push_back(wb + ADDR_W'(i));
            addr_q1.push_back(wb + ADDR_W'(i));
        end
        start = 1'b1;
        @(posedge clk); #1;
        t0 = gcyc - 1;
        pass_on = 1'b1;
        if (!hold_start) start = 1'b0;
        for (rel = 1; rel < 300; rel++) begin
            hold     = rel < hold_until;
            inj      = (rel >= 3) && (rel <= 5);
            ff_empty = emp && (rel % 4 == 3);
            if (|done) start = 1'b0;
            if (abort && rel > 11 && iss[0] >= 2) begin
                rst = 1'b1; start = 1'b0; pass_on = 1'b0;
                break;
            end
            if (rel > 1 && busy == 2'b00) break;
            @(posedge clk); #1;
        end
        if (!abort) begin
            @(negedge clk); #1;
            pass_on = 1'b0;
            start = 1'b0;
            chk("pass_end", busy, 0);
            for (int g = 0; g < 2; g++) begin
                chk("wren_n", wren_n[g], TAPS);
                chk("cwl_n", cwl_n[g], TAPS);
                chk("cwl_first", cwl_first[g], 2);
                chk("cwl_last", cwl_last[g], 10);
                chk("early_pop", popmask[g][10:0], 0);
                chk("done_n", done_n[g], 1);
                chk("done_cyc", done_cyc[g], (nw == 0) ? 11 : ret_cyc[g] + 1);
                chk("busy_drop", drop_cyc[g], done_cyc[g] + 1);
                chk("psum_final", psum_count[g], nw);
                chk("wload_err", wload_err[g], kil);
            end
            chk("addr_left", addr_q0.size() + addr_q1.size(), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Weight load then 3 windows; limit 4 pops back to back, limit 2 stalls one slot.
        run_pass(10'h100, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pops_max4", popmask[0][15:11], 5'b00111);
        chk("pops_max2", popmask[1][15:11], 5'b10011);

        // Returns withheld until cycle 20: pops stop at the credit limit.
        run_pass(10'h040, 6, 20, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_max4", popmask[0][21:11], 11'b10000001111);
        chk("hold_max2", popmask[1][21:11], 11'b10000000011);

        // Intermittently empty FIFO.
        run_pass(10'h200, 6, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Zero windows with wrapping weight addresses.
        run_pass(10'h3FE, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nopop_0", popmask[0], 0);
        chk("nopop_1", popmask[1], 0);

        // Weight-load handshake never completes: error is sticky until the next start.
        run_pass(10'h010, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky_0", wload_err[0], 1);
        chk("err_sticky_1", wload_err[1], 1);

        // Start held high for the whole pass must not retrigger.
        run_pass(10'h3FC, 4, 0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-stream, then a clean pass.
        run_pass(10'h080, 6, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("abort");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
        end
        run_pass(10'h090, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Stray psum returns while idle are ignored.
        inj = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        inj = 1'b0;
        chk("idle_psum_0", psum_count[0], 5);
        chk("idle_psum_1", psum_count[1], 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
